dffreg_arbiter: RTL and testbench

Round-robin write arbiter for a shared flip-flop register in the flip-flop datapath library. Up to N_REQ requesters compete for one WIDTH-bit storage register; the block grants one requester per write slot, captures that requester's data into the register, and reports the register contents and last writer. It sits between requester logic and the shared state element, sequencing all loads into it.

---
 rtl/dffreg_arb_pkg.sv | 17 +
 rtl/dffreg_arbiter_rr_pick.sv | 34 +++
 rtl/dffreg_arbiter.sv | 110 +++++++++++
 tb/tb_dffreg_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dffreg_arb_pkg.sv
// dffreg_arb_pkg: shared types and helpers for the dffreg_arbiter slice.
// State encoding for the grant FSM and the index-width helper used for
// ptr/owner sizing.
package dffreg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dffreg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans requesters starting at
// i_ptr (wrapping), skipping masked ones, and returns the first hit as a
// one-hot vector plus its index. Holds no state.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // First unmasked request at or after the pointer wins.
    always_comb begin
        int c;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        c        = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(i_ptr) + k;
            if (c >= N) c = c - N;
            if (!o_any && i_req[c] && !i_mask[c]) begin
                o_any       = 1'b1;
                o_onehot[c] = 1'b1;
                o_idx       = IW'(c);
            end
        end
    end

endmodule

// File: rtl/dffreg_arbiter.sv
// dffreg_arbiter: round-robin write arbiter for one shared WIDTH-bit register.
// Grants are registered one-hot; the granted requester's data is captured on
// the edge that ends its grant cycle. Defining DFFREG_ARB_LOCK_EN adds the
// lock port and the LOCKED state, which holds a grant across cycles.
module dffreg_arbiter
    import dffreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
`ifdef DFFREG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]           lock,
`endif
    output logic [N_REQ-1:0]           gnt,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [idx_w(N_REQ)-1:0]    owner
);

    localparam int IW = idx_w(N_REQ);

    arb_state_e       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_inc, w_ptr_arb;
    logic [N_REQ-1:0] w_pick;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_wr, w_hold;
    logic [WIDTH-1:0] w_wsel, r_q;
    logic             r_q_valid;
    logic [IW-1:0]    r_owner;

    // Any non-idle cycle is a write cycle for the currently granted requester.
    assign w_wr      = (r_state != ST_IDLE);
    assign w_ptr_inc = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
    // Arbitrate from the pointer value this cycle's write will leave behind,
    // so a requester arriving mid-grant is ordered fairly.
    assign w_ptr_arb = w_wr ? w_ptr_inc : r_ptr;
    assign w_wsel    = wdata[int'(r_idx)*WIDTH +: WIDTH];

`ifdef DFFREG_ARB_LOCK_EN
    assign w_hold = w_wr && lock[r_idx];
`else
    assign w_hold = 1'b0;
`endif

    // The granted requester is masked: its req during gnt is the handshake.
    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req    (req),
        .i_mask   (r_gnt),
        .i_ptr    (w_ptr_arb),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Next state and next grant: hold under lock, else re-arbitrate.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = r_idx;
        if (w_hold) begin
            w_state_nxt = ST_LOCKED;
            w_gnt_nxt   = r_gnt;
        end else if (w_pick_any) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = w_pick;
            w_idx_nxt   = w_pick_idx;
        end
    end

    // FSM state and registered grant.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Shared register, last writer and pointer update at the end of a grant cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= '0;
        end else if (w_wr) begin
            r_q       <= w_wsel;
            r_q_valid <= 1'b1;
            r_owner   <= r_idx;
            r_ptr     <= w_ptr_inc;
        end
    end

    assign gnt     = r_gnt;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign owner   = r_owner;

endmodule

// File: tb/tb_dffreg_arbiter.sv
// tb_dffreg_arbiter: directed-vector bench for dffreg_arbiter (N_REQ=4, WIDTH=8).
module tb_dffreg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           res;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
`ifdef DFFREG_ARB_LOCK_EN
    logic [N-1:0]   lock = '0;
`endif
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [1:0]     owner;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dffreg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .wdata   (wdata),
`ifdef DFFREG_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    logic [N-1:0] exp_gnt [5];
    logic [W-1:0] exp_q   [5];

    initial begin
        res   = 1'b0;
        req   = 4'b1111;
        wdata = '0;
        for (int i = 0; i < N; i++) set_wd(i, W'(i + 1));

        // Reset held with all requests up: nothing moves.
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qv", 32'(q_valid), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);

        // Release: first grant one edge later, then strict rotation.
        res = 1'b1;
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_qv", 32'(q_valid), 32'h0);
        exp_gnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_q   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fair_gnt%0d", k), 32'(gnt), 32'(exp_gnt[k]));
            chk($sformatf("fair_q%0d", k), 32'(q), 32'(exp_q[k]));
            chk($sformatf("fair_own%0d", k), 32'(owner), 32'(k));
        end
        chk("fair_qv", 32'(q_valid), 32'h1);

        // Drop requests while gnt[0] is up: write still lands, ptr -> 1.
        req = 4'b0000;
        tick();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_q", 32'(q), 32'h1);
        chk("drop_owner", 32'(owner), 32'h0);

        // Single requester: granted every other cycle.
        set_wd(2, 8'hA5);
        req = 4'b0100;
        tick(); chk("single_g1", 32'(gnt), 32'h4);
        tick(); chk("single_g2", 32'(gnt), 32'h0);
                chk("single_q", 32'(q), 32'hA5);
                chk("single_own", 32'(owner), 32'h2);
        tick(); chk("single_g3", 32'(gnt), 32'h4);
        tick(); chk("single_g4", 32'(gnt), 32'h0);

        // Wrap: ptr=3, req 3 and 0 -> gnt[3] then gnt[0], ptr ends 1.
        req = 4'b1001;
        tick(); chk("wrap_g3", 32'(gnt), 32'h8);
        tick(); chk("wrap_g0", 32'(gnt), 32'h1);
                chk("wrap_q3", 32'(q), 32'h4);
                chk("wrap_own3", 32'(owner), 32'h3);
        req = 4'b0000;
        tick(); chk("wrap_idle", 32'(gnt), 32'h0);
                chk("wrap_q0", 32'(q), 32'h1);
                chk("wrap_own0", 32'(owner), 32'h0);
        req = 4'b1111;
        tick(); chk("wrap_ptr1", 32'(gnt), 32'h2);

        // Reset mid-grant of requester 1: immediate abort, write discarded.
        set_wd(1, 8'h3C);
        #2 res = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_qv", 32'(q_valid), 32'h0);
        tick();
        chk("midrst_q_hold", 32'(q), 32'h0);
        chk("midrst_gnt_hold", 32'(gnt), 32'h0);
        req = 4'b0000;
        res = 1'b1;
        tick();
        chk("post_idle", 32'(gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Backstop in case the sequence above stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
